// File: rtl/regfile_mport.sv
// regfile_mport: parametrised multi-port register file for the ID stage.
//   - NUM_RD combinational read ports, NUM_WR write ports (highest index wins).
//   - Optional hard-wired zero entry and write->read bypass.
//   - Storage is zeroed by a sequential clear engine (one entry per cycle)
//     after reset or on clr_req, so the array itself carries no reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_req         one-cycle pulse in RUN starts a full clear
//   rR / rd         packed read addresses / read data, port i at [i*W +: W]
//   we / wR / wD    per-port write enable, address, data
//   ready / busy    RUN / CLEAR state indication (busy == ~ready)

// One read lane: stored value, optional bypass from this cycle's writes,
// zero-register override, and forced 0 while the clear engine runs.
module regfile_mport_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                   run_i,
    input  logic [ADDR_W-1:0]                      addr_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     mem_i,
    input  logic [NUM_WR-1:0]                      we_i,
    input  logic [NUM_WR*ADDR_W-1:0]               wr_i,
    input  logic [NUM_WR*DATA_W-1:0]               wd_i,
    output logic [DATA_W-1:0]                      data_o
);
    always_comb begin
        data_o = '0;
        if (run_i) begin
            data_o = mem_i[addr_i];
            // Ascending scan so the highest-index matching port wins.
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we_i[j] && (wr_i[j*ADDR_W +: ADDR_W] == addr_i))
                        data_o = wd_i[j*DATA_W +: DATA_W];
                end
            end
            // Zero register overrides any bypassed value.
            if ((ZERO_REG != 0) && (addr_i == '0))
                data_o = '0;
        end
    end
endmodule

module regfile_mport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    input  logic [NUM_RD*ADDR_W-1:0]   rR,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   wR,
    input  logic [NUM_WR*DATA_W-1:0]   wD,
    output logic                       ready,
    output logic                       busy
);
    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so the counter can reach DEPTH without wrapping.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             clr_cnt_q, clr_cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    generate
        if (NUM_WR < 1 || NUM_WR > 4 || NUM_RD < 1) begin : g_bad_param
            $error("regfile_mport: unsupported NUM_RD/NUM_WR");
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + CNT_W'(1);
                if (clr_cnt_q == CNT_W'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage: clear engine owns the array in CLEAR; in RUN the ports write,
    // later ports overriding earlier ones on an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && !((ZERO_REG != 0) && (wR[j*ADDR_W +: ADDR_W] == '0)))
                        mem_q[wR[j*ADDR_W +: ADDR_W]] <= wD[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign ready = (state_q == RUN);
    assign busy  = ~ready;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            regfile_mport_rdport #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .NUM_WR  (NUM_WR),
                .ZERO_REG(ZERO_REG),
                .BYPASS  (BYPASS)
            ) u_rd (
                .run_i (ready),
                .addr_i(rR[i*ADDR_W +: ADDR_W]),
                .mem_i (mem_q),
                .we_i  (we),
                .wr_i  (wR),
                .wd_i  (wD),
                .data_o(rd[i*DATA_W +: DATA_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mport.sv
// Bench for regfile_mport: two instances (bypass on / off) share all inputs.
module tb_regfile_mport;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst, clr_req;
    logic [NR*AW-1:0]  rR;
    logic [NR*DW-1:0]  rd_b, rd_n;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  wR;
    logic [NW*DW-1:0]  wD;
    logic              rdy_b, busy_b, rdy_n, busy_n;

    int total = 0;
    int bad   = 0;

    regfile_mport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .rR(rR), .rd(rd_b),
        .we(we), .wR(wR), .wD(wD), .ready(rdy_b), .busy(busy_b));

    regfile_mport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .rR(rR), .rd(rd_n),
        .we(we), .wR(wR), .wD(wD), .ready(rdy_n), .busy(busy_n));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  w0, w1;
        logic [31:0] d0, d1;
        logic [4:0]  r0, r1;
        logic [31:0] eb0, eb1, en0, en1;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = '0;
        wR      = '0;
        wD      = '0;
        clr_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rR = {AW'(31 - i), AW'(i)};
            #1;
            chk($sformatf("%s_b_e%0d", tag, i), rd_b[DW-1:0], 32'h0);
            chk($sformatf("%s_n_e%0d", tag, i), rd_n[DW-1:0], 32'h0);
            chk($sformatf("%s_b_e%0d", tag, 31 - i), rd_b[2*DW-1:DW], 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        //                we     w0     w1     d0            d1            r0     r1     eb0           eb1           en0           en1
        vt[0]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vt[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vt[2]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vt[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vt[4]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       5'd7,  5'd7,  32'h22,       32'h22,       32'h0,        32'h0};
        vt[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 32'h22,       32'hDEADBEEF};
        vt[6]  = '{2'b11, 5'd3,  5'd4,  32'hA5A5,     32'h5A5A,     5'd3,  5'd4,  32'hA5A5,     32'h5A5A,     32'h0,        32'h0};
        vt[7]  = '{2'b01, 5'd3,  5'd0,  32'h1234,     32'h0,        5'd3,  5'd4,  32'h1234,     32'h5A5A,     32'hA5A5,     32'h5A5A};
        vt[8]  = '{2'b10, 5'd4,  5'd31, 32'hFFFF,     32'hCAFEF00D, 5'd4,  5'd31, 32'h5A5A,     32'hCAFEF00D, 32'h5A5A,     32'h0};
        vt[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  5'd31, 32'h1234,     32'hCAFEF00D, 32'h1234,     32'hCAFEF00D};
        vt[10] = '{2'b11, 5'd0,  5'd0,  32'h77,       32'h88,       5'd0,  5'd7,  32'h0,        32'h22,       32'h0,        32'h22};

        // Reset, then the initial clear; writes to entry 9 throughout must be dropped.
        idle();
        rR  = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ready_b", 32'(rdy_b), 32'h0);
        chk("rst_busy_b",  32'(busy_b), 32'h1);
        chk("rst_ready_n", 32'(rdy_n), 32'h0);
        we = 2'b01;
        wR = {5'd0, 5'd9};
        wD = {32'h0, 32'h55};
        rR = {5'd9, 5'd9};
        n  = 0;
        while (rdy_b !== 1'b1 && n < 100) begin
            if (n == 3) begin
                #1;
                chk("init_clr_rd_b", rd_b[DW-1:0], 32'h0);
                chk("init_clr_rd_n", rd_n[DW-1:0], 32'h0);
            end
            step();
            n++;
        end
        chk("init_clr_cycles", 32'(n), 32'd32);
        chk("init_ready_n", 32'(rdy_n), 32'h1);
        chk("init_busy_b", 32'(busy_b), 32'h0);
        idle();
        check_all_zero("init_zero");

        // Table-driven RUN vectors: same-cycle reads, bypass, zero reg, collisions.
        for (int k = 0; k < 11; k++) begin
            we = vt[k].we;
            wR = {vt[k].w1, vt[k].w0};
            wD = {vt[k].d1, vt[k].d0};
            rR = {vt[k].r1, vt[k].r0};
            #1;
            chk($sformatf("vec%0d_b_r0", k), rd_b[DW-1:0],    vt[k].eb0);
            chk($sformatf("vec%0d_b_r1", k), rd_b[2*DW-1:DW], vt[k].eb1);
            chk($sformatf("vec%0d_n_r0", k), rd_n[DW-1:0],    vt[k].en0);
            chk($sformatf("vec%0d_n_r1", k), rd_n[2*DW-1:DW], vt[k].en1);
            step();
        end
        idle();

        // Fill 1..31, then clr_req: writes ignored and clr_req ignored while busy.
        for (int i = 1; i < 32; i++) begin
            we = 2'b01;
            wR = {5'd0, AW'(i)};
            wD = {32'h0, 32'(i) * 32'h01010101};
            step();
        end
        idle();
        rR = {5'd31, 5'd1};
        #1;
        chk("fill_e1",  rd_b[DW-1:0],    32'h01010101);
        chk("fill_e31", rd_n[2*DW-1:DW], 32'h1F1F1F1F);
        clr_req = 1'b1;
        we = 2'b01;
        wR = {5'd0, 5'd20};
        wD = {32'h0, 32'hBAD};
        #1;
        chk("clrreq_ready_before", 32'(rdy_b), 32'h1);
        step();
        idle();
        chk("clrreq_ready_after", 32'(rdy_b), 32'h0);
        chk("clrreq_busy_after",  32'(busy_n), 32'h1);
        n = 0;
        while (rdy_b !== 1'b1 && n < 100) begin
            we      = 2'b11;
            wR      = {AW'(n + 31), 5'd31};
            wD      = {32'hABCD0000 | 32'(n), 32'h31313131};
            rR      = {AW'(n + 31), 5'd31};
            clr_req = (n == 4 || n == 20);
            if (n == 5) begin
                #1;
                chk("clr_nobypass_r0", rd_b[DW-1:0],    32'h0);
                chk("clr_nobypass_r1", rd_b[2*DW-1:DW], 32'h0);
            end
            step();
            n++;
        end
        chk("req_clr_cycles", 32'(n), 32'd32);
        idle();
        check_all_zero("req_zero");

        // Reset in the middle of a clear restarts it from entry 0.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", 32'(rdy_b), 32'h0);
        n = 0;
        while (rdy_b !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("midrst_cycles", 32'(n), 32'd32);

        // Back in RUN: a write is visible (bypass same cycle, stored next cycle).
        we = 2'b01;
        wR = {5'd0, 5'd12};
        wD = {32'h0, 32'h600D};
        rR = {5'd12, 5'd12};
        #1;
        chk("post_bypass_b", rd_b[DW-1:0], 32'h600D);
        chk("post_bypass_n", rd_n[DW-1:0], 32'h0);
        step();
        idle();
        #1;
        chk("post_stored_b", rd_b[2*DW-1:DW], 32'h600D);
        chk("post_stored_n", rd_n[DW-1:0],    32'h600D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
